// File: rtl/capture_ctrl.sv
// capture_ctrl: pre/post-trigger acquisition sequencer for a 512-entry sample RAM.
// Define CAPTURE_AUTO_TRIG_EN to force a trigger after 2^20 clocks in ARMED.
module capture_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture,
  input  logic       trig1,
  input  logic       trig2,
  input  logic       trig_src,
  input  logic       trig_edge,
  input  logic [8:0] trig_pos,
  input  logic [3:0] decimator,
  output logic       adc_clk,
  output logic       en,
  output logic       we,
  output logic [8:0] addr,
  output logic [8:0] trig_addr,
  output logic       busy,
  output logic       done,
  output logic       auto_trig
);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync1;
  logic [SYNC_STAGES-1:0] sync2;
  logic                   trig_prev;
  logic                   trig_cur;
  logic                   qual_edge;
  logic                   timeout;
  logic                   trig_hit;

  logic                   cfg_src;
  logic                   cfg_edge;
  logic [8:0]             cfg_pos;
  logic [3:0]             cfg_dec;

  logic [15:0]            dec_cnt;
  logic [15:0]            dec_mask;
  logic [9:0]             pre_cnt;
  logic [9:0]             pre_len;
  logic [8:0]             post_cnt;
  logic                   armed_first;
  logic                   writing;
  logic                   wr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      trig_prev <= 1'b0;
    end else begin
      sync1     <= {sync1[SYNC_STAGES-2:0], trig1};
      sync2     <= {sync2[SYNC_STAGES-2:0], trig2};
      trig_prev <= trig_cur;
    end
  end

  always_comb begin
    trig_cur  = cfg_src ? sync2[SYNC_STAGES-1] : sync1[SYNC_STAGES-1];
    qual_edge = cfg_edge ? (trig_cur & ~trig_prev) : (~trig_cur & trig_prev);
    trig_hit  = (qual_edge && !armed_first) || timeout;
    dec_mask  = ~(16'hFFFF << cfg_dec);
    pre_len   = 10'd512 - {1'b0, cfg_pos};
    writing   = (state == PRE) || (state == ARMED) || (state == POST);
    // en is registered: the next cycle is a slot when adc_clk is low now, and
    // dec_cnt only moves on slot cycles, so its current value is the next one.
    wr_next   = ~adc_clk && (dec_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      adc_clk     <= 1'b0;
      en          <= 1'b0;
      we          <= 1'b0;
      addr        <= '0;
      trig_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_src     <= 1'b0;
      cfg_edge    <= 1'b0;
      cfg_pos     <= '0;
      cfg_dec     <= '0;
      dec_cnt     <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      armed_first <= 1'b0;
    end else begin
      adc_clk     <= ~adc_clk;
      done        <= 1'b0;
      armed_first <= 1'b0;
      if (en) addr <= addr + 9'd1;
      if (adc_clk && writing) dec_cnt <= (dec_cnt == dec_mask) ? '0 : dec_cnt + 16'd1;

      case (state)
        IDLE: begin
          en <= 1'b0;
          we <= 1'b0;
          if (capture) begin
            state    <= PRE;
            busy     <= 1'b1;
            addr     <= '0;
            dec_cnt  <= '0;
            pre_cnt  <= '0;
            cfg_src  <= trig_src;
            cfg_edge <= trig_edge;
            cfg_pos  <= trig_pos;
            cfg_dec  <= decimator;
            en       <= ~adc_clk;
            we       <= ~adc_clk;
          end
        end

        PRE: begin
          en <= wr_next;
          we <= wr_next;
          if (en) begin
            if (pre_cnt == pre_len - 10'd1) begin
              state       <= ARMED;
              armed_first <= 1'b1;
            end else begin
              pre_cnt <= pre_cnt + 10'd1;
            end
          end
        end

        ARMED: begin
          en <= wr_next;
          we <= wr_next;
          if (trig_hit) begin
            // A write landing on the edge cycle is still pre-trigger data.
            trig_addr <= en ? addr + 9'd1 : addr;
            if (cfg_pos == '0) begin
              state <= DONE;
              done  <= 1'b1;
              en    <= 1'b0;
              we    <= 1'b0;
            end else begin
              state    <= POST;
              post_cnt <= cfg_pos;
            end
          end
        end

        POST: begin
          en <= wr_next;
          we <= wr_next;
          if (en) begin
            if (post_cnt == 9'd1) begin
              state <= DONE;
              done  <= 1'b1;
              en    <= 1'b0;
              we    <= 1'b0;
            end else begin
              post_cnt <= post_cnt - 9'd1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          en    <= 1'b0;
          we    <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          en    <= 1'b0;
          we    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAPTURE_AUTO_TRIG_EN
  logic [19:0] to_cnt;

  assign timeout = (state == ARMED) && (to_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      auto_trig <= 1'b0;
    end else begin
      to_cnt <= (state == ARMED) ? to_cnt + 20'd1 : '0;
      if (state == IDLE && capture) begin
        auto_trig <= 1'b0;
      end else if (timeout && !(qual_edge && !armed_first)) begin
        auto_trig <= 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign auto_trig = 1'b0;
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: table of capture scenarios plus reset and no-trigger sequences,
// with a write scoreboard holding the expected cycle and address of every RAM write.
module tb_capture_ctrl;

  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       capture = 1'b0;
  logic       trig1 = 1'b0;
  logic       trig2 = 1'b0;
  logic       trig_src = 1'b0;
  logic       trig_edge = 1'b1;
  logic [8:0] trig_pos = '0;
  logic [3:0] decimator = '0;
  logic       adc_clk;
  logic       en;
  logic       we;
  logic [8:0] addr;
  logic [8:0] trig_addr;
  logic       busy;
  logic       done;
  logic       auto_trig;

  capture_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .trig1     (trig1),
    .trig2     (trig2),
    .trig_src  (trig_src),
    .trig_edge (trig_edge),
    .trig_pos  (trig_pos),
    .decimator (decimator),
    .adc_clk   (adc_clk),
    .en        (en),
    .we        (we),
    .addr      (addr),
    .trig_addr (trig_addr),
    .busy      (busy),
    .done      (done),
    .auto_trig (auto_trig)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Times are in cycles relative to the capture cycle; d_on/d_off = 0 means no decoy.
  typedef struct {
    bit src;
    bit edge_dir;
    int pos;
    int dec;
    int d_on;
    int d_off;
    int fire;
    int ta;
    int fa;
    int tot;
  } vec_t;

  typedef struct {
    int cyc;
    int a;
  } wr_t;

  vec_t vecs[7];
  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt;
  int   done_cyc;
  int   post_wr;
  int   q_abs;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t w;
    if (!rst_n) return;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (en) begin
      if (cyc > q_abs) post_wr++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL extra_write cyc=%0d addr=%0d required no write", cyc, addr);
      end else begin
        w = sb.pop_front();
        if (w.cyc != cyc || int'(addr) != w.a || we !== 1'b1) begin
          errors++;
          $display("FAIL write cyc=%0d addr=%0d we=%b required cyc=%0d addr=%0d we=1",
                   cyc, addr, we, w.cyc, w.a);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      w = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write cyc=%0d en=0 required write at cyc=%0d addr=%0d", cyc, w.cyc, w.a);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic drive_sel(input bit s, input logic lvl);
    if (s) trig2 = lvl;
    else   trig1 = lvl;
  endtask

  task automatic push_writes(input int c, input int p, input int n);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      w.cyc = c + 1 + k * p;
      w.a   = k % 512;
      sb.push_back(w);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_adc_clk"}, adc_clk, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_trig_addr"}, trig_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_auto_trig"}, auto_trig, 0);
  endtask

  task automatic align_even();
    do step(); while (cyc % 2 != 0);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int   c;
    int   p;
    int   done_rel;
    logic act;
    p         = 2 << v.dec;
    act       = v.edge_dir;
    trig_src  = v.src;
    trig_edge = v.edge_dir;
    trig_pos  = 9'(v.pos);
    decimator = 4'(v.dec);
    trig1     = ~act;
    trig2     = ~act;
    done_cnt  = 0;
    post_wr   = 0;
    q_abs     = 32'h7fffffff;
    repeat (4) step();
    align_even();
    c = cyc;
    chk($sformatf("row%0d_adc_phase", idx), adc_clk, 0);
    q_abs = c + v.fire + int'(SYNC);
    push_writes(c, p, v.tot);
    capture = 1'b1;
    for (int r = 1; r <= 12000 && done_cnt == 0; r++) begin
      step();
      capture = (r == v.fire - 30);
      if (r == v.fire - 30) begin
        trig_src  = ~v.src;
        trig_edge = ~v.edge_dir;
        trig_pos  = 9'd7;
        decimator = 4'(v.dec ^ 1);
      end
      if (r == v.d_on)      drive_sel(v.src, act);
      if (r == v.d_off)     drive_sel(v.src, ~act);
      if (r == v.fire - 10) drive_sel(~v.src, act);
      if (r == v.fire)      drive_sel(v.src, act);
    end
    chk($sformatf("row%0d_done_seen", idx), done_cnt, 1);
    done_rel = (v.pos == 0) ? v.fire + int'(SYNC) + 1 : 2 + (v.tot - 1) * p;
    chk($sformatf("row%0d_done_cycle", idx), done_cyc - c, done_rel);
    step();
    chk($sformatf("row%0d_busy_after_done", idx), busy, 0);
    repeat (3) step();
    chk($sformatf("row%0d_done_pulses", idx), done_cnt, 1);
    chk($sformatf("row%0d_trig_addr", idx), trig_addr, v.ta);
    chk($sformatf("row%0d_final_addr", idx), addr, v.fa);
    chk($sformatf("row%0d_post_writes", idx), post_wr, v.pos);
    chk($sformatf("row%0d_pending_writes", idx), sb.size(), 0);
    chk($sformatf("row%0d_auto_trig", idx), auto_trig, 0);
    sb.delete();
  endtask

  initial begin
    int c;
    //          src   edge  pos  dec d_on d_off fire  ta   fa   tot
    vecs[0] = '{1'b0, 1'b1, 256, 0,  0,   0,    2000, 489, 233, 1257};
    vecs[1] = '{1'b0, 1'b1, 100, 0,  99,  150,  1000, 501, 89,  601};
    vecs[2] = '{1'b1, 1'b1, 20,  3,  0,   0,    8000, 501, 9,   521};
    vecs[3] = '{1'b1, 1'b0, 0,   0,  0,   0,    1100, 39,  39,  551};
    vecs[4] = '{1'b0, 1'b0, 5,   1,  0,   0,    2099, 14,  19,  531};
    vecs[5] = '{1'b0, 1'b1, 400, 0,  222, 230,  300,  151, 39,  551};
    vecs[6] = '{1'b1, 1'b1, 3,   0,  0,   0,    1017, 510, 1,   513};
    q_abs    = 32'h7fffffff;
    done_cnt = 0;
    post_wr  = 0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_row(i, vecs[i]);

    // No trigger ever arrives: capture must stay busy in ARMED.
    trig_src  = 1'b0;
    trig_edge = 1'b1;
    trig_pos  = 9'd500;
    decimator = 4'd0;
    trig1     = 1'b0;
    trig2     = 1'b0;
    done_cnt  = 0;
    q_abs     = 32'h7fffffff;
    repeat (4) step();
    align_even();
    c = cyc;
    push_writes(c, 2, 750);
    capture = 1'b1;
    for (int r = 1; r <= 1500; r++) begin
      step();
      capture = 1'b0;
    end
    chk("notrig_busy", busy, 1);
    chk("notrig_done", done_cnt, 0);
    chk("notrig_auto_trig", auto_trig, 0);
    chk("notrig_pending_writes", sb.size(), 0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("rst_armed");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of POST, then a clean restart.
    trig_pos = 9'd200;
    trig1    = 1'b0;
    done_cnt = 0;
    repeat (4) step();
    align_even();
    c = cyc;
    push_writes(c, 2, 375);
    capture = 1'b1;
    for (int r = 1; r <= 750; r++) begin
      step();
      capture = 1'b0;
      if (r == 700) trig1 = 1'b1;
    end
    chk("post_busy_before_reset", busy, 1);
    chk("post_pending_writes", sb.size(), 0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("rst_post");
    @(negedge clk);
    rst_n = 1'b1;
    run_row(7, vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on trig1/trig2, legal values 2..3.
REQ-002 clk  input  1  system clock, 40 MHz; all state on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 capture  input  1  one-cycle pulse; arms a new acquisition.
REQ-005 trig1, trig2  input  1 each  asynchronous trigger comparators from AFE.
REQ-006 trig_src  input  1  0 = trig1, 1 = trig2.
REQ-007 trig_edge  input  1  1 = rising, 0 = falling.
REQ-008 trig_pos  input  9  samples stored after trigger, 0..511.
REQ-009 decimator  input  4  store one of every 2^decimator ADC samples.
REQ-010 adc_clk  output  1  clk/2 to ADCs.
REQ-011 en, we  output  1 each  RAM512 enable / write enable.
REQ-012 addr  output  9  RAM512 address.
REQ-013 trig_addr  output  9  RAM address of first post-trigger sample.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at end of capture.
REQ-016 auto_trig  output  1  high when last capture ended by timeout.

Function
REQ-017 adc_clk toggles every clk cycle; sample slot is each cycle with adc_clk high.
REQ-018 Decimation counter, 16 bits, advances per sample slot; a write occurs on a slot where counter == 0; counter wraps at (2^decimator)-1.
REQ-019 On a write cycle en = we = 1 and data is written at addr; addr increments mod 512 on the following clk; otherwise en = we = 0.
REQ-020 States: IDLE, PRE, ARMED, POST, DONE.
REQ-021 IDLE: no writes; capture pulse -> PRE, addr cleared to 0, decimation counter cleared, pre counter cleared, auto_trig cleared.
REQ-022 PRE: write; after (512 - trig_pos) writes -> ARMED; trigger edges ignored.
REQ-023 ARMED: write circularly; qualified edge -> trig_addr = address of next write, post counter loaded with trig_pos, -> POST (or -> DONE if trig_pos == 0, trig_addr = current addr).
REQ-024 POST: write; after trig_pos writes -> DONE.
REQ-025 DONE: done = 1 for one cycle, -> IDLE; addr holds final value.
REQ-026 Qualified edge: selected trigger after SYNC_STAGES flops compared with a one-cycle-delayed copy; rising = 0->1, falling = 1->0.
REQ-027 trig_src, trig_edge, trig_pos, decimator are sampled at capture pulse; changes during busy are ignored.
REQ-028 capture while busy is ignored.
REQ-029 Edge coinciding with the ARMED entry cycle is ignored; first eligible edge is the cycle after entry.

Reset
REQ-030 rst_n low, at any time including mid-capture: state = IDLE, adc_clk = 0, en = we = 0, addr = 0, trig_addr = 0, busy = 0, done = 0, auto_trig = 0, synchronizers = 0, all counters = 0.

Configuration
REQ-031 Macro CAPTURE_AUTO_TRIG_EN defined: 20-bit timeout counter runs in ARMED; at 2^20 clocks without a qualified edge a trigger is forced per REQ-023 and auto_trig is set until next capture.
REQ-032 Macro undefined: ARMED waits indefinitely; auto_trig constant 0; no timeout logic synthesized.

Verification
REQ-033 trig_pos=256, decimator=0, rising edge on trig1 at 2000 clk after capture -> 256 pre writes, trig_addr = addr at edge, 256 post writes, done pulse once, busy low next cycle.
REQ-034 Edge on trig1 during PRE (trig_pos=100, edge at write 50) -> ignored; capture completes only on a later edge in ARMED.
REQ-035 decimator=3 -> en pulses every 16 clk; addr increments by 1 per pulse; wraps 511->0.
REQ-036 trig_pos=0, falling edge on trig2 with trig_src=1 -> DONE next cycle, no post writes, trig_addr = addr at edge.
REQ-037 rst_n low mid-POST -> all outputs at reset values same cycle; a new capture pulse restarts cleanly from addr 0.
REQ-038 CAPTURE_AUTO_TRIG_EN defined, no trigger -> forced trigger 1,048,576 clk after ARMED entry, auto_trig = 1, done pulses; undefined -> busy stays 1.
